// File: rtl/msj_setpoint_shaper.sv
// Setpoint shaper: debounced jog buttons and host loads set a clamped target;
// sp slews toward it at max_step per tick, with a hold (freeze) state.
module msj_setpoint_shaper #(
    parameter int CLOCK_SPEED_HZ = 50_000_000,
    parameter int DEBOUNCE_MS    = 10,
    parameter int BUTTON_STEP    = 10,
    parameter int SP_MAX         = 100000,
    parameter int SP_MIN         = -100000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               target_valid,
    input  logic signed [31:0] target_in,
    input  logic        [15:0] max_step,
    input  logic               pull_button_n,
    input  logic               release_button_n,
    input  logic               zero_button_n,
    input  logic               hold,
    output logic signed [31:0] sp,
    output logic signed [31:0] target,
    output logic               busy,
    output logic               at_target
);

    localparam longint unsigned DB_RAW =
        (longint'(DEBOUNCE_MS) * longint'(CLOCK_SPEED_HZ)) / 1000;
    localparam int unsigned DB_CYCLES = (DB_RAW < 1) ? 1 : int'(DB_RAW);
    localparam int unsigned CW        = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    state_t state, state_next;

    // Button bit order: [0] pull, [1] release, [2] zero; levels are active-low.
    logic [2:0]    raw;
    logic [2:0]    sync1, sync2, stable;
    logic [CW-1:0] cnt [3];
    logic          pull_on, release_on, zero_on;

    assign raw = {zero_button_n, release_button_n, pull_button_n};

    // Counter only runs while the synchronized level differs from the debounced
    // one, so any bounce back to the debounced level restarts it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1  <= '1;
            sync2  <= '1;
            stable <= '1;
            for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign pull_on    = ~stable[0];
    assign release_on = ~stable[1];
    assign zero_on    = ~stable[2];

    logic signed [31:0] sp_next, target_next;
    logic signed [32:0] tgt_ext, sp_ext, diff, jog;
    logic        [32:0] mag;

    always_comb begin
        tgt_ext = {target[31], target};
        sp_ext  = {sp[31], sp};
        diff    = tgt_ext - sp_ext;
        mag     = diff[32] ? 33'(-diff) : 33'(diff);
        jog     = tgt_ext;

        sp_next = sp;
        if (!hold && state == RAMP && tick) begin
            if (max_step == '0 || mag <= {17'b0, max_step})
                sp_next = target;
            else if (diff[32])
                sp_next = sp - $signed({16'b0, max_step});
            else
                sp_next = sp + $signed({16'b0, max_step});
        end

        target_next = target;
        if (hold || state == HOLD) begin
            target_next = sp;
        end else if (zero_on) begin
            target_next = '0;
        end else if (target_valid) begin
            if (target_in > SP_MAX)      target_next = SP_MAX;
            else if (target_in < SP_MIN) target_next = SP_MIN;
            else                         target_next = target_in;
        end else if (tick && (pull_on != release_on)) begin
            jog = pull_on ? tgt_ext + 33'(BUTTON_STEP) : tgt_ext - 33'(BUTTON_STEP);
            if (jog > 33'(SP_MAX))      target_next = SP_MAX;
            else if (jog < 33'(SP_MIN)) target_next = SP_MIN;
            else                        target_next = jog[31:0];
        end
    end

    // Transitions look at next-cycle sp/target so busy and at_target settle together.
    always_comb begin
        state_next = state;
        if (hold) begin
            state_next = HOLD;
        end else begin
            case (state)
                IDLE:    if (sp_next != target_next) state_next = RAMP;
                RAMP:    if (sp_next == target_next) state_next = IDLE;
                HOLD:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sp     <= '0;
            target <= '0;
        end else begin
            state  <= state_next;
            sp     <= sp_next;
            target <= target_next;
        end
    end

    assign busy      = (state == RAMP);
    assign at_target = (sp == target);

endmodule
